// File: rtl/morse_pkg.sv
// Shared constants for the morse message sequencer: letter width, default
// symbols per letter and the controller state encoding.
package morse_pkg;

  localparam int LETTER_W = 3;
  localparam int SYM_LEN  = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/morse_letter_fifo.sv
// Small synchronous letter queue: registered read/write pointers plus an
// occupancy count. Push when full and pop when empty are ignored.
module morse_letter_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/morse_sequencer.sv
// Message-level controller: queues letters, loads each into the morse shift
// register, strobes SYM_LEN shifts at the symbol rate, then a silent gap.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int SYM_LEN    = morse_pkg::SYM_LEN,
  parameter int GAP_TICKS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [LETTER_W-1:0] in_letter,
  output logic                in_ready,
  output logic [LETTER_W-1:0] sel,
  output logic                sr_load,
  output logic                sr_shift,
  output logic                tick,
  output logic                busy,
  output logic                done
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BIT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SYM_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  logic [1:0]          state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [LETTER_W-1:0] sel_q, sel_d;
  logic                sr_load_q, sr_load_d;
  logic                sr_shift_q, sr_shift_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LETTER_W-1:0] fifo_dout;
  logic                timed, tick_c;

  assign in_ready  = !fifo_full && !reset;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == ST_LOAD);

  morse_letter_fifo #(
    .WIDTH(LETTER_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (in_letter),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // The divider only runs while a letter is being timed.
  assign timed  = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign tick_c = timed && (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = '0;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sel_d      = sel_q;
    sr_load_d  = 1'b0;
    sr_shift_d = 1'b0;
    tick_d     = tick_c;
    done_d     = 1'b0;

    if (timed && !tick_c) div_cnt_d = div_cnt_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sel_d     = fifo_dout;
        bit_cnt_d = '0;
        sr_load_d = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick_c) begin
          sr_shift_d = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick_c) begin
          if (gap_cnt_q == GAP_LAST) begin
            done_d  = 1'b1;
            state_d = fifo_empty ? ST_IDLE : ST_LOAD;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered, so each lands one cycle after its decision point.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sel_q      <= '0;
      sr_load_q  <= 1'b0;
      sr_shift_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sel_q      <= sel_d;
      sr_load_q  <= sr_load_d;
      sr_shift_q <= sr_shift_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end

  assign sel      = sel_q;
  assign sr_load  = sr_load_q;
  assign sr_shift = sr_shift_q;
  assign tick     = tick_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: one instance at TICK_DIV=4 and one at TICK_DIV=1,
// a negedge event monitor with a letter scoreboard, vector table plus sequences.
module tb_morse_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]      rst_w, in_valid_w, in_ready_w;
  logic [1:0]      sr_load_w, sr_shift_w, tick_w, busy_w, done_w;
  logic [1:0][2:0] in_letter_w, sel_w;

  morse_sequencer #(.TICK_DIV(4), .SYM_LEN(12), .GAP_TICKS(3), .FIFO_DEPTH(4)) dut0 (
    .clock(clock), .reset(rst_w[0]), .in_valid(in_valid_w[0]), .in_letter(in_letter_w[0]),
    .in_ready(in_ready_w[0]), .sel(sel_w[0]), .sr_load(sr_load_w[0]), .sr_shift(sr_shift_w[0]),
    .tick(tick_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  morse_sequencer #(.TICK_DIV(1), .SYM_LEN(12), .GAP_TICKS(3), .FIFO_DEPTH(4)) dut1 (
    .clock(clock), .reset(rst_w[1]), .in_valid(in_valid_w[1]), .in_letter(in_letter_w[1]),
    .in_ready(in_ready_w[1]), .sel(sel_w[1]), .sr_load(sr_load_w[1]), .sr_shift(sr_shift_w[1]),
    .tick(tick_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int load_cnt[2], shift_cnt[2], first_shift_cyc[2], last_shift_cyc[2], spacing_err[2];
  int done_cnt[2], done_cyc[2], done_shifts[2], done_ticks[2], tick_cnt[2];
  int last_load_cyc[2], b2b_cnt[2], busy_low[2], ready_low[2], push_cnt[2], push_cyc[2];
  int sel_err[2];
  logic [2:0] last_load_sel[2];
  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Outputs in cycle k are seen here with cyc==k; a handshake seen here is
  // taken at edge k+1.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (sr_load_w[d]) begin
        load_cnt[d]++;
        if (done_cnt[d] > 0 && done_cyc[d] == cyc - 1) b2b_cnt[d]++;
        last_load_cyc[d] = cyc;
        last_load_sel[d] = sel_w[d];
        shift_cnt[d] = 0;
        spacing_err[d] = 0;
        tick_cnt[d] = 0;
        if (d == 0) begin
          if (exp_q0.size() == 0) sel_err[d]++;
          else if (exp_q0.pop_front() != sel_w[d]) sel_err[d]++;
        end else begin
          if (exp_q1.size() == 0) sel_err[d]++;
          else if (exp_q1.pop_front() != sel_w[d]) sel_err[d]++;
        end
      end
      if (tick_w[d]) tick_cnt[d]++;
      if (sr_shift_w[d]) begin
        if (shift_cnt[d] == 0) first_shift_cyc[d] = cyc;
        else if (cyc - last_shift_cyc[d] != ((d == 0) ? 4 : 1)) spacing_err[d]++;
        last_shift_cyc[d] = cyc;
        shift_cnt[d]++;
      end
      if (done_w[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
        done_shifts[d] = shift_cnt[d];
        done_ticks[d] = tick_cnt[d];
      end
      if (!busy_w[d] && !done_w[d]) busy_low[d]++;
      if (!in_ready_w[d] && !rst_w[d]) ready_low[d]++;
      if (rst_w[d]) begin
        if (d == 0) exp_q0.delete();
        else exp_q1.delete();
      end else if (in_valid_w[d] && in_ready_w[d]) begin
        push_cnt[d]++;
        push_cyc[d] = cyc + 1;
        if (d == 0) exp_q0.push_back(in_letter_w[d]);
        else exp_q1.push_back(in_letter_w[d]);
      end
    end
  end

  typedef struct {
    int         d;
    logic [2:0] letter;
    int         load_lat;
    int         first_shift;
    int         done_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input int d, input int target, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (done_cnt[d] >= target) break;
      step();
    end
    chk(name, done_cnt[d], target);
  endtask

  initial begin
    int base, base2, base3, base4;
    logic [2:0] fill[4];

    vecs[0] = '{0, 3'b100, 2, 4, 60};
    vecs[1] = '{0, 3'b011, 2, 4, 60};
    vecs[2] = '{1, 3'b111, 2, 1, 15};
    vecs[3] = '{1, 3'b010, 2, 1, 15};
    fill[0] = 3'd1; fill[1] = 3'd2; fill[2] = 3'd3; fill[3] = 3'd6;

    rst_w = 2'b11;
    in_valid_w = 2'b00;
    in_letter_w = '0;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_sel", sel_w[d], 0);
      chk("rst_sr_load", sr_load_w[d], 0);
      chk("rst_sr_shift", sr_shift_w[d], 0);
      chk("rst_tick", tick_w[d], 0);
      chk("rst_busy", busy_w[d], 0);
      chk("rst_done", done_w[d], 0);
      chk("rst_in_ready", in_ready_w[d], 0);
    end
    rst_w = 2'b00;
    step();
    for (int d = 0; d < 2; d++) chk("ready_after_rst", in_ready_w[d], 1);

    // Single letters on both divider settings.
    foreach (vecs[v]) begin
      int d;
      d = vecs[v].d;
      base = ready_low[d];
      base2 = push_cnt[d];
      base3 = done_cnt[d];
      in_letter_w[d] = vecs[v].letter;
      in_valid_w[d] = 1'b1;
      step();
      in_valid_w[d] = 1'b0;
      chk("single_push", push_cnt[d] - base2, 1);
      wait_done(d, base3 + 1, 300, "single_done");
      chk("load_latency", last_load_cyc[d] - push_cyc[d], vecs[v].load_lat);
      chk("load_sel", last_load_sel[d], vecs[v].letter);
      chk("first_shift", first_shift_cyc[d] - last_load_cyc[d], vecs[v].first_shift);
      chk("shift_count", done_shifts[d], 12);
      chk("shift_spacing", spacing_err[d], 0);
      chk("done_latency", done_cyc[d] - last_load_cyc[d], vecs[v].done_lat);
      chk("tick_count", done_ticks[d], 15);
      chk("busy_after_done", busy_w[d], 0);
      chk("ready_held", ready_low[d] - base, 0);
    end

    // Three letters back to back.
    base = load_cnt[0];
    base2 = b2b_cnt[0];
    base3 = done_cnt[0];
    base4 = push_cnt[0];
    in_valid_w[0] = 1'b1;
    in_letter_w[0] = 3'b000;
    step();
    in_letter_w[0] = 3'b001;
    step();
    begin
      int busy_base;
      busy_base = busy_low[0];
      in_letter_w[0] = 3'b010;
      step();
      in_valid_w[0] = 1'b0;
      chk("b2b_pushes", push_cnt[0] - base4, 3);
      wait_done(0, base3 + 3, 800, "b2b_done");
      chk("b2b_loads", load_cnt[0] - base, 3);
      chk("b2b_no_idle", b2b_cnt[0] - base2, 2);
      chk("b2b_busy_held", busy_low[0] - busy_base, 0);
      chk("b2b_last_sel", last_load_sel[0], 3'b010);
    end
    chk("b2b_order", sel_err[0], 0);

    // Fill the queue behind a playing letter, junk while full, then a held push.
    base = load_cnt[0];
    base3 = done_cnt[0];
    in_letter_w[0] = 3'b101;
    in_valid_w[0] = 1'b1;
    step();
    in_valid_w[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (load_cnt[0] != base) break;
      step();
    end
    chk("fill_first_load", load_cnt[0] - base, 1);
    base2 = push_cnt[0];
    for (int k = 0; k < 4; k++) begin
      in_letter_w[0] = fill[k];
      in_valid_w[0] = 1'b1;
      step();
    end
    in_valid_w[0] = 1'b0;
    chk("fill_pushes", push_cnt[0] - base2, 4);
    chk("full_ready", in_ready_w[0], 0);
    base2 = push_cnt[0];
    for (int i = 0; i < 8; i++) begin
      in_valid_w[0] = ((i % 2) == 0);
      in_letter_w[0] = 3'(i);
      step();
      chk("full_ready_junk", in_ready_w[0], 0);
    end
    chk("full_no_push", push_cnt[0] - base2, 0);
    in_letter_w[0] = 3'b100;
    in_valid_w[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (push_cnt[0] != base2) break;
    end
    in_valid_w[0] = 1'b0;
    chk("held_accepted", push_cnt[0] - base2, 1);
    chk("held_after_pop", push_cyc[0] - last_load_cyc[0], 1);
    wait_done(0, base3 + 6, 900, "fill_done");
    chk("fill_loads", load_cnt[0] - base, 6);
    chk("fill_last_sel", last_load_sel[0], 3'b100);
    chk("fill_order", sel_err[0], 0);
    chk("fill_queue_drained", exp_q0.size(), 0);

    // Reset in the middle of a letter with two letters still queued.
    base = load_cnt[0];
    in_valid_w[0] = 1'b1;
    in_letter_w[0] = 3'b111;
    step();
    in_letter_w[0] = 3'b110;
    step();
    in_letter_w[0] = 3'b101;
    step();
    in_valid_w[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (load_cnt[0] != base && shift_cnt[0] >= 5) break;
      step();
    end
    chk("mid_shift_count", shift_cnt[0], 5);
    base3 = done_cnt[0];
    base2 = load_cnt[0];
    rst_w[0] = 1'b1;
    step();
    chk("mid_rst_busy", busy_w[0], 0);
    chk("mid_rst_sr_shift", sr_shift_w[0], 0);
    chk("mid_rst_sr_load", sr_load_w[0], 0);
    chk("mid_rst_sel", sel_w[0], 0);
    chk("mid_rst_done", done_w[0], 0);
    rst_w[0] = 1'b0;
    step();
    chk("mid_rst_ready", in_ready_w[0], 1);
    for (int i = 0; i < 100; i++) step();
    chk("mid_rst_idle", busy_w[0], 0);
    chk("mid_rst_no_load", load_cnt[0] - base2, 0);
    chk("mid_rst_no_done", done_cnt[0] - base3, 0);
    chk("mid_rst_order", sel_err[0], 0);
    chk("fast_order", sel_err[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
